// File: rtl/ccip_tx_shim_buffer.sv
// Per-AFU elastic Tx stage between an AFU and a CCI-P mux leaf: c0/c1 request FIFOs, local almost-full, c2 register.
// Optional stall counters are built when CCIP_TX_SHIM_STATS_EN is defined.

typedef logic [73:0]  t_ccip_c0_ReqHdr;
typedef logic [79:0]  t_ccip_c1_ReqHdr;
typedef logic [511:0] t_ccip_clData;
typedef logic [8:0]   t_ccip_c2_RspHdr;
typedef logic [63:0]  t_ccip_mmioData;
typedef logic [27:0]  t_ccip_RspHdr;

typedef struct packed {
    t_ccip_c0_ReqHdr hdr;
    logic            valid;
} t_if_ccip_c0_Tx;

typedef struct packed {
    t_ccip_c1_ReqHdr hdr;
    t_ccip_clData    data;
    logic            valid;
} t_if_ccip_c1_Tx;

typedef struct packed {
    t_ccip_c2_RspHdr hdr;
    t_ccip_mmioData  data;
    logic            valid;
} t_if_ccip_c2_Tx;

typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
} t_if_ccip_Tx;

typedef struct packed {
    t_ccip_RspHdr hdr;
    t_ccip_clData data;
    logic         rspValid;
    logic         mmioRdValid;
    logic         mmioWrValid;
} t_if_ccip_c0_Rx;

typedef struct packed {
    t_ccip_RspHdr hdr;
    logic         rspValid;
} t_if_ccip_c1_Rx;

typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
} t_if_ccip_Rx;

module ccip_tx_shim_buffer #(
    parameter int DEPTH         = 16,
    parameter int ALMFULL_SLACK = 8
) (
    input  logic        pClk,
    input  logic        SoftReset_n,
    input  t_if_ccip_Tx afu_TxPort,
    output t_if_ccip_Rx afu_RxPort,
    input  t_if_ccip_Rx mux_RxPort,
    output t_if_ccip_Tx mux_TxPort,
    output logic        overflow_err
`ifdef CCIP_TX_SHIM_STATS_EN
    ,
    output logic [15:0] c0_stall_cnt,
    output logic [15:0] c1_stall_cnt
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - ALMFULL_SLACK);

    function automatic logic [15:0] satInc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [CNT_W-1:0] nextCount(input logic [CNT_W-1:0] cnt,
                                                   input logic push, input logic pop);
        return cnt + CNT_W'(push) - CNT_W'(pop);
    endfunction

    t_ccip_c0_ReqHdr c0Mem     [DEPTH];
    t_ccip_c1_ReqHdr c1HdrMem  [DEPTH];
    t_ccip_clData    c1DataMem [DEPTH];

    logic [PTR_W-1:0] c0WrPtr, c0RdPtr, c1WrPtr, c1RdPtr;
    logic [CNT_W-1:0] c0Cnt, c1Cnt, c0CntNext, c1CntNext;
    logic             c0Push, c0Pop, c0Drop, c1Push, c1Pop, c1Drop;

    t_ccip_c0_ReqHdr  c0Hdr_p1;
    t_ccip_c1_ReqHdr  c1Hdr_p1;
    t_ccip_clData     c1Data_p1;
    t_ccip_c2_RspHdr  c2Hdr_p1;
    t_ccip_mmioData   c2Data_p1;
    logic             c0Vld_p1, c1Vld_p1, c2Vld_p1;
    logic             c0AlmFull_p1, c1AlmFull_p1;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is only dropped without one.
    always_comb begin
        c0Pop  = (c0Cnt != '0) && !mux_RxPort.c0TxAlmFull;
        c0Push = afu_TxPort.c0.valid && ((c0Cnt != FULL_CNT) || c0Pop);
        c0Drop = afu_TxPort.c0.valid && !c0Push;
        c1Pop  = (c1Cnt != '0) && !mux_RxPort.c1TxAlmFull;
        c1Push = afu_TxPort.c1.valid && ((c1Cnt != FULL_CNT) || c1Pop);
        c1Drop = afu_TxPort.c1.valid && !c1Push;
    end

    assign c0CntNext = nextCount(c0Cnt, c0Push, c0Pop);
    assign c1CntNext = nextCount(c1Cnt, c1Push, c1Pop);

    // Stage p0 -> p1: FIFO storage and output data registers (no reset on data).
    always_ff @(posedge pClk) begin
        if (c0Push) c0Mem[c0WrPtr] <= afu_TxPort.c0.hdr;
        if (c1Push) begin
            c1HdrMem[c1WrPtr]  <= afu_TxPort.c1.hdr;
            c1DataMem[c1WrPtr] <= afu_TxPort.c1.data;
        end
        if (c0Pop) c0Hdr_p1 <= c0Mem[c0RdPtr];
        if (c1Pop) begin
            c1Hdr_p1  <= c1HdrMem[c1RdPtr];
            c1Data_p1 <= c1DataMem[c1RdPtr];
        end
        c2Hdr_p1  <= afu_TxPort.c2.hdr;
        c2Data_p1 <= afu_TxPort.c2.data;
    end

    always_ff @(posedge pClk) begin
        if (!SoftReset_n) begin
            c0WrPtr      <= '0;
            c0RdPtr      <= '0;
            c0Cnt        <= '0;
            c1WrPtr      <= '0;
            c1RdPtr      <= '0;
            c1Cnt        <= '0;
            c0Vld_p1     <= 1'b0;
            c1Vld_p1     <= 1'b0;
            c2Vld_p1     <= 1'b0;
            c0AlmFull_p1 <= 1'b1;
            c1AlmFull_p1 <= 1'b1;
            overflow_err <= 1'b0;
        end else begin
            if (c0Push) c0WrPtr <= c0WrPtr + PTR_W'(1);
            if (c0Pop)  c0RdPtr <= c0RdPtr + PTR_W'(1);
            if (c1Push) c1WrPtr <= c1WrPtr + PTR_W'(1);
            if (c1Pop)  c1RdPtr <= c1RdPtr + PTR_W'(1);
            c0Cnt        <= c0CntNext;
            c1Cnt        <= c1CntNext;
            c0Vld_p1     <= c0Pop;
            c1Vld_p1     <= c1Pop;
            c2Vld_p1     <= afu_TxPort.c2.valid;
            c0AlmFull_p1 <= (c0CntNext >= AF_CNT);
            c1AlmFull_p1 <= (c1CntNext >= AF_CNT);
            overflow_err <= overflow_err | c0Drop | c1Drop;
        end
    end

`ifdef CCIP_TX_SHIM_STATS_EN
    always_ff @(posedge pClk) begin
        if (!SoftReset_n) begin
            c0_stall_cnt <= '0;
            c1_stall_cnt <= '0;
        end else begin
            if ((c0Cnt != '0) && mux_RxPort.c0TxAlmFull) c0_stall_cnt <= satInc16(c0_stall_cnt);
            if ((c1Cnt != '0) && mux_RxPort.c1TxAlmFull) c1_stall_cnt <= satInc16(c1_stall_cnt);
        end
    end
`endif

    always_comb begin
        mux_TxPort          = '0;
        mux_TxPort.c0.hdr   = c0Hdr_p1;
        mux_TxPort.c0.valid = c0Vld_p1;
        mux_TxPort.c1.hdr   = c1Hdr_p1;
        mux_TxPort.c1.data  = c1Data_p1;
        mux_TxPort.c1.valid = c1Vld_p1;
        mux_TxPort.c2.hdr   = c2Hdr_p1;
        mux_TxPort.c2.data  = c2Data_p1;
        mux_TxPort.c2.valid = c2Vld_p1;
    end

    // Rx is a straight copy except that the AFU sees the shim's own almost-full.
    always_comb begin
        afu_RxPort             = mux_RxPort;
        afu_RxPort.c0TxAlmFull = c0AlmFull_p1;
        afu_RxPort.c1TxAlmFull = c1AlmFull_p1;
    end

endmodule

// File: tb/tb_ccip_tx_shim_buffer.sv
// Bench for ccip_tx_shim_buffer: queue-based reference model checked every cycle, plus directed scenarios.
module tb_ccip_tx_shim_buffer;
    localparam int DEPTH = 16;
    localparam int SLACK = 8;

    typedef struct packed { logic [73:0] hdr; logic valid; } c0tx_t;
    typedef struct packed { logic [79:0] hdr; logic [511:0] data; logic valid; } c1tx_t;
    typedef struct packed { logic [8:0] hdr; logic [63:0] data; logic valid; } c2tx_t;
    typedef struct packed { c0tx_t c0; c1tx_t c1; c2tx_t c2; } tx_t;
    typedef struct packed { logic [27:0] hdr; logic [511:0] data; logic rspValid; logic mmioRdValid; logic mmioWrValid; } c0rx_t;
    typedef struct packed { logic [27:0] hdr; logic rspValid; } c1rx_t;
    typedef struct packed { logic c0TxAlmFull; logic c1TxAlmFull; c0rx_t c0; c1rx_t c1; } rx_t;
    typedef struct packed { logic [79:0] h; logic [511:0] d; } c1e_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    tx_t  afuTx, muxTx;
    rx_t  afuRx, muxRx;
    logic ovf;
`ifdef CCIP_TX_SHIM_STATS_EN
    logic [15:0] st0, st1;
`endif

    ccip_tx_shim_buffer #(.DEPTH(DEPTH), .ALMFULL_SLACK(SLACK)) dut (
        .pClk(clk),
        .SoftReset_n(rst_n),
        .afu_TxPort(afuTx),
        .afu_RxPort(afuRx),
        .mux_RxPort(muxRx),
        .mux_TxPort(muxTx),
        .overflow_err(ovf)
`ifdef CCIP_TX_SHIM_STATS_EN
        ,
        .c0_stall_cnt(st0),
        .c1_stall_cnt(st1)
`endif
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: queues per channel, updated from the inputs seen at each rising edge.
    logic [73:0] q0[$];
    c1e_t        q1[$];
    logic        eVld0, eVld1, eC2Vld, eAf0, eAf1, eOvf;
    logic [73:0] eHdr0;
    c1e_t        eC1;
    logic [8:0]  eC2Hdr;
    logic [63:0] eC2Data;
    int          eSt0, eSt1;
    bit          modelLive = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            eVld0 = 0; eVld1 = 0; eC2Vld = 0;
            eAf0 = 1; eAf1 = 1; eOvf = 0;
            eSt0 = 0; eSt1 = 0;
        end else begin
            if (q0.size() > 0 && muxRx.c0TxAlmFull && eSt0 < 65535) eSt0 = eSt0 + 1;
            if (q1.size() > 0 && muxRx.c1TxAlmFull && eSt1 < 65535) eSt1 = eSt1 + 1;
            eVld0 = 0;
            if (q0.size() > 0 && !muxRx.c0TxAlmFull) begin eVld0 = 1; eHdr0 = q0.pop_front(); end
            eVld1 = 0;
            if (q1.size() > 0 && !muxRx.c1TxAlmFull) begin eVld1 = 1; eC1 = q1.pop_front(); end
            if (afuTx.c0.valid) begin
                if (q0.size() < DEPTH) q0.push_back(afuTx.c0.hdr); else eOvf = 1;
            end
            if (afuTx.c1.valid) begin
                if (q1.size() < DEPTH) q1.push_back({afuTx.c1.hdr, afuTx.c1.data}); else eOvf = 1;
            end
            eAf0 = (q0.size() >= DEPTH - SLACK);
            eAf1 = (q1.size() >= DEPTH - SLACK);
            eC2Vld = afuTx.c2.valid;
            eC2Hdr = afuTx.c2.hdr;
            eC2Data = afuTx.c2.data;
        end
        modelLive = 1;
    end

    always @(negedge clk) begin
        if (modelLive) begin
            check("m_c0_valid", 512'(muxTx.c0.valid), 512'(eVld0));
            if (eVld0) check("m_c0_hdr", 512'(muxTx.c0.hdr), 512'(eHdr0));
            check("m_c1_valid", 512'(muxTx.c1.valid), 512'(eVld1));
            if (eVld1) begin
                check("m_c1_hdr", 512'(muxTx.c1.hdr), 512'(eC1.h));
                check("m_c1_data", muxTx.c1.data, eC1.d);
            end
            check("m_c2_valid", 512'(muxTx.c2.valid), 512'(eC2Vld));
            if (eC2Vld) check("m_c2_payload", 512'({muxTx.c2.hdr, muxTx.c2.data}), 512'({eC2Hdr, eC2Data}));
            check("m_c0_almfull", 512'(afuRx.c0TxAlmFull), 512'(eAf0));
            check("m_c1_almfull", 512'(afuRx.c1TxAlmFull), 512'(eAf1));
            check("m_overflow", 512'(ovf), 512'(eOvf));
            check("m_rx_c0_data", afuRx.c0.data, muxRx.c0.data);
            check("m_rx_misc", 512'({afuRx.c0.hdr, afuRx.c0.rspValid, afuRx.c0.mmioRdValid, afuRx.c0.mmioWrValid, afuRx.c1}),
                  512'({muxRx.c0.hdr, muxRx.c0.rspValid, muxRx.c0.mmioRdValid, muxRx.c0.mmioWrValid, muxRx.c1}));
`ifdef CCIP_TX_SHIM_STATS_EN
            check("m_c0_stall", 512'(st0), 512'(eSt0));
            check("m_c1_stall", 512'(st1), 512'(eSt1));
`endif
        end
    end

    // Advance one edge, then refresh the Rx pass-through pattern away from the edge.
    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
        muxRx.c0.hdr = 28'(cyc * 7);
        muxRx.c0.data = {16{32'(cyc)}};
        muxRx.c0.rspValid = cyc[0];
        muxRx.c0.mmioRdValid = cyc[1];
        muxRx.c0.mmioWrValid = cyc[2];
        muxRx.c1.hdr = 28'(cyc) ^ 28'h5A5_A5A5;
        muxRx.c1.rspValid = cyc[3];
    endtask

    task automatic drainC0(input int base, input int expN, input int budget, input string nm);
        int got = 0;
        for (int i = 0; i < budget; i++) begin
            if (muxTx.c0.valid) begin
                check(nm, 512'(muxTx.c0.hdr), 512'(74'(base + got)));
                got++;
            end
            step();
        end
        check({nm, "_count"}, 512'(got), 512'(expN));
    endtask

    initial begin
        int got, first, last;
        rst_n = 1'b0;
        afuTx = '0;
        muxRx = '0;

        for (int i = 0; i < 3; i++) step();
        check("reset_af0", 512'(afuRx.c0TxAlmFull), 512'(1'b1));
        check("reset_af1", 512'(afuRx.c1TxAlmFull), 512'(1'b1));
        check("reset_vld0", 512'(muxTx.c0.valid), 512'(1'b0));
        check("reset_vld1", 512'(muxTx.c1.valid), 512'(1'b0));
        check("reset_ovf", 512'(ovf), 512'(1'b0));
        rst_n = 1'b1;
        step();
        check("af0_after_reset", 512'(afuRx.c0TxAlmFull), 512'(1'b0));
        check("af1_after_reset", 512'(afuRx.c1TxAlmFull), 512'(1'b0));

        // Idle pass-through, two-edge latency on c0, one-edge on c2.
        for (int i = 0; i < 4; i++) step();
        afuTx.c0.valid = 1'b1;
        afuTx.c0.hdr = 74'h1_2345_6789_ABCD_EF01;
        afuTx.c2.valid = 1'b1;
        afuTx.c2.hdr = 9'h1A5;
        afuTx.c2.data = 64'hDEAD_BEEF_CAFE_F00D;
        step();
        afuTx.c0.valid = 1'b0;
        afuTx.c2.valid = 1'b0;
        check("idle_c0_not_yet", 512'(muxTx.c0.valid), 512'(1'b0));
        check("idle_c2_valid", 512'(muxTx.c2.valid), 512'(1'b1));
        check("idle_c2_data", 512'(muxTx.c2.data), 512'(64'hDEAD_BEEF_CAFE_F00D));
        check("idle_c2_hdr", 512'(muxTx.c2.hdr), 512'(9'h1A5));
        step();
        check("idle_c0_valid", 512'(muxTx.c0.valid), 512'(1'b1));
        check("idle_c0_hdr", 512'(muxTx.c0.hdr), 512'(74'h1_2345_6789_ABCD_EF01));
        check("idle_c0_af", 512'(afuRx.c0TxAlmFull), 512'(1'b0));
        check("idle_c2_done", 512'(muxTx.c2.valid), 512'(1'b0));
        step();
        check("idle_c0_single", 512'(muxTx.c0.valid), 512'(1'b0));
        afuTx.c1.valid = 1'b1;
        afuTx.c1.hdr = 80'hAAAA_0000_1111_2222_3333;
        afuTx.c1.data = {8{64'h0123_4567_89AB_CDEF}};
        step();
        afuTx.c1.valid = 1'b0;
        step();
        check("idle_c1_valid", 512'(muxTx.c1.valid), 512'(1'b1));
        check("idle_c1_hdr", 512'(muxTx.c1.hdr), 512'(80'hAAAA_0000_1111_2222_3333));
        check("idle_c1_data", muxTx.c1.data, {8{64'h0123_4567_89AB_CDEF}});
        step();

        // c1 back-pressure: eight writes raise the AFU almost-full, then drain in order.
        muxRx.c1TxAlmFull = 1'b1;
        for (int i = 0; i < 8; i++) begin
            afuTx.c1.valid = 1'b1;
            afuTx.c1.hdr = 80'(100 + i);
            afuTx.c1.data = {16{32'hA5A5_0000 + 32'(i)}};
            step();
            if (i == 6) check("bp_af1_at7", 512'(afuRx.c1TxAlmFull), 512'(1'b0));
        end
        afuTx.c1.valid = 1'b0;
        check("bp_af1_at8", 512'(afuRx.c1TxAlmFull), 512'(1'b1));
        check("bp_no_vld1", 512'(muxTx.c1.valid), 512'(1'b0));
        muxRx.c1TxAlmFull = 1'b0;
        got = 0; first = -1; last = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (muxTx.c1.valid) begin
                check("bp_c1_hdr", 512'(muxTx.c1.hdr), 512'(80'(100 + got)));
                check("bp_c1_data", muxTx.c1.data, {16{32'hA5A5_0000 + 32'(got)}});
                if (first < 0) first = i;
                last = i;
                got++;
            end
        end
        check("bp_c1_count", 512'(got), 512'(8));
        check("bp_c1_back_to_back", 512'(last - first), 512'(7));

        // Overflow: seventeenth push into a stalled full FIFO is dropped.
        muxRx.c0TxAlmFull = 1'b1;
        for (int i = 0; i < 17; i++) begin
            afuTx.c0.valid = 1'b1;
            afuTx.c0.hdr = 74'(200 + i);
            step();
            if (i == 15) check("ovf_at16", 512'(ovf), 512'(1'b0));
        end
        afuTx.c0.valid = 1'b0;
        check("ovf_at17", 512'(ovf), 512'(1'b1));
        muxRx.c0TxAlmFull = 1'b0;
        drainC0(200, 16, 24, "ovf_drain_hdr");
        check("ovf_sticky", 512'(ovf), 512'(1'b1));
        rst_n = 1'b0;
        step();
        check("ovf_cleared", 512'(ovf), 512'(1'b0));
        rst_n = 1'b1;
        step();

        // Full FIFO with a simultaneous pop accepts the extra push.
        muxRx.c0TxAlmFull = 1'b1;
        for (int i = 0; i < 16; i++) begin
            afuTx.c0.valid = 1'b1;
            afuTx.c0.hdr = 74'(300 + i);
            step();
        end
        muxRx.c0TxAlmFull = 1'b0;
        afuTx.c0.hdr = 74'(316);
        step();
        afuTx.c0.valid = 1'b0;
        check("fullpp_ovf", 512'(ovf), 512'(1'b0));
        drainC0(300, 17, 24, "fullpp_drain_hdr");
        check("fullpp_ovf_end", 512'(ovf), 512'(1'b0));

        // Reset in the middle of a drain discards the remaining entries.
        muxRx.c0TxAlmFull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            afuTx.c0.valid = 1'b1;
            afuTx.c0.hdr = 74'(400 + i);
            step();
        end
        afuTx.c0.valid = 1'b0;
        muxRx.c0TxAlmFull = 1'b0;
        step();
        check("rst_mid_pop1", 512'(muxTx.c0.hdr), 512'(74'(400)));
        step();
        check("rst_mid_pop2", 512'(muxTx.c0.hdr), 512'(74'(401)));
        rst_n = 1'b0;
        step();
        check("rst_mid_af0", 512'(afuRx.c0TxAlmFull), 512'(1'b1));
        check("rst_mid_vld0", 512'(muxTx.c0.valid), 512'(1'b0));
        rst_n = 1'b1;
        step();
        check("rst_mid_af0_after", 512'(afuRx.c0TxAlmFull), 512'(1'b0));
        for (int i = 0; i < 10; i++) begin
            check("rst_mid_no_vld0", 512'(muxTx.c0.valid), 512'(1'b0));
            step();
        end

`ifdef CCIP_TX_SHIM_STATS_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        muxRx.c0TxAlmFull = 1'b1;
        afuTx.c0.valid = 1'b1;
        afuTx.c0.hdr = 74'h55;
        step();
        afuTx.c0.valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("stats_c0", 512'(st0), 512'(16'd20));
        check("stats_c1", 512'(st1), 512'(16'd0));
        muxRx.c0TxAlmFull = 1'b0;
        step();
        check("stats_c0_drain", 512'(muxTx.c0.hdr), 512'(74'h55));
`endif

        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
